// File: rtl/hsv_core_commit.sv
// Commit/writeback stage: in-order commit FIFO, register writeback, retire and flush/redirect.
// Optional retired-instruction counter enabled by defining HSV_CORE_INSTRET_EN.
module hsv_core_commit #(
    parameter int          FIFO_DEPTH  = 2,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0000
) (
    input  logic        clk_core,
    input  logic        rst_core_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rd_value,
    input  logic        in_rd_write,
    input  logic        in_jump,
    input  logic [31:0] in_next_pc,
    input  logic        in_trap,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic        trap,
    output logic [63:0] instret
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rd_value;
        logic        rd_write;
        logic        jump;
        logic [31:0] next_pc;
        logic        trap;
    } entry_t;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t           r_state;
    entry_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    entry_t w_in_entry;
    entry_t w_head;
    logic   w_push;
    logic   w_pop;
    logic   w_redirect;

    assign w_in_entry = {in_pc, in_rd, in_rd_value, in_rd_write, in_jump, in_next_pc, in_trap};
    assign w_head     = r_mem[r_rd_ptr];
    assign in_ready   = (r_state == ST_RUN) && (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == ST_RUN) && (r_count != '0);
    assign w_redirect = w_pop && (w_head.jump || w_head.trap);

    // Entry storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_core) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_state      <= ST_RUN;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            flush        <= 1'b0;
            flush_target <= '0;
            trap         <= 1'b0;
        end else begin
            retire_valid <= w_pop;
            wb_en        <= w_pop && w_head.rd_write && !w_head.trap && (w_head.rd != 5'd0);
            trap         <= w_pop && w_head.trap;
            flush        <= w_redirect;

            if (w_pop) begin
                retire_pc <= w_head.pc;
                wb_rd     <= w_head.rd;
                wb_data   <= w_head.rd_value;
            end

            // A redirect empties the buffer, including anything accepted on the same edge.
            if (w_redirect) begin
                flush_target <= w_head.trap ? TRAP_VECTOR : w_head.next_pc;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            case (r_state)
                ST_RUN:   r_state <= w_redirect ? ST_FLUSH : ST_RUN;
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

`ifdef HSV_CORE_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_instret <= '0;
        end else if (w_pop && !w_head.trap) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_hsv_core_commit.sv
// Scoreboard bench for hsv_core_commit; instret expectations follow HSV_CORE_INSTRET_EN.
module tb_hsv_core_commit;
    localparam logic [31:0] TV = 32'h0000_1C00;
`ifdef HSV_CORE_INSTRET_EN
    localparam bit IEN = 1'b1;
`else
    localparam bit IEN = 1'b0;
`endif

    logic        clk_core = 1'b0;
    logic        rst_core_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_rd_value = '0;
    logic        in_rd_write = 1'b0;
    logic        in_jump = 1'b0;
    logic [31:0] in_next_pc = '0;
    logic        in_trap = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        flush;
    logic [31:0] flush_target;
    logic        trap;
    logic [63:0] instret;

    hsv_core_commit #(.FIFO_DEPTH(2), .TRAP_VECTOR(TV)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rd(in_rd), .in_rd_value(in_rd_value),
        .in_rd_write(in_rd_write), .in_jump(in_jump), .in_next_pc(in_next_pc),
        .in_trap(in_trap),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .flush(flush), .flush_target(flush_target), .trap(trap),
        .instret(instret)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wb;
        logic        trp;
        logic        fl;
        logic [31:0] tgt;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] exp_instret = '0;

    always @(posedge clk_core) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every retire against the head of the scoreboard.
    always @(negedge clk_core) begin
        if (rst_core_n) begin
            if (retire_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire pc %0h expected no retire", retire_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (IEN && !e.trp) exp_instret = exp_instret + 64'd1;
                    chk("retire_pc", retire_pc, e.pc);
                    chk("latency", cyc - e.acc, 2);
                    chk("wb_en", wb_en, e.wb);
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                    chk("trap", trap, e.trp);
                    chk("flush", flush, e.fl);
                    if (e.fl) chk("flush_target", flush_target, e.tgt);
                    chk("instret", instret, exp_instret);
                end
            end else begin
                chk("idle_pulses", {flush, wb_en, trap}, 3'b000);
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val,
                        input logic wr, input logic jmp, input logic [31:0] npc, input logic trp,
                        input bit keep, input logic exp_wb, input logic exp_fl,
                        input logic [31:0] exp_tgt, output int stalls);
        exp_t e;
        bit   done;
        logic rdy;
        in_pc = pc; in_rd = rd; in_rd_value = val; in_rd_write = wr;
        in_jump = jmp; in_next_pc = npc; in_trap = trp; in_valid = 1'b1;
        stalls = 0;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            rdy = in_ready;
            @(posedge clk_core);
            if (rdy) begin
                done = 1'b1;
                if (keep) begin
                    e.pc = pc; e.rd = rd; e.data = val; e.wb = exp_wb; e.trp = trp;
                    e.fl = exp_fl; e.tgt = exp_tgt; e.acc = cyc;
                    sb.push_back(e);
                end
            end else begin
                stalls++;
            end
            @(negedge clk_core);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pc %0h got no acceptance expected acceptance", pc);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk_core);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {retire_valid, wb_en, flush, trap}, 4'b0000);
        chk({tag, "_wb_rd"}, wb_rd, 5'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_retire_pc"}, retire_pc, 32'd0);
        chk({tag, "_flush_target"}, flush_target, 32'd0);
        chk({tag, "_instret"}, instret, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int st;
        repeat (3) @(negedge clk_core);
        rst_core_n = 1'b1;
        chk_all_zero("reset");
        chk("reset_in_ready", in_ready, 1'b1);

        send(32'h100, 5'd5, 32'hDEADBEEF, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, st);
        idle(3);
        chk("instret_t1", instret, IEN ? 64'd1 : 64'd0);

        send(32'h104, 5'd0, 32'h1234, 1, 0, 32'h0, 0, 1, 0, 0, 32'h0, st);
        idle(3);
        chk("instret_x0", instret, IEN ? 64'd2 : 64'd0);

        for (int i = 0; i < 8; i++) begin
            send(32'h1000 + 32'(4 * i), 5'(i + 1), 32'hA000_0000 + 32'(i), 1, 0, 32'h0, 0,
                 1, 1, 0, 32'h0, st);
            chk("stream_stalls", st, 0);
        end
        idle(3);
        chk("instret_stream", instret, IEN ? 64'd10 : 64'd0);

        send(32'h200, 5'd1, 32'h204, 1, 1, 32'h400, 0, 1, 1, 1, 32'h400, st);
        send(32'h204, 5'd2, 32'h11, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, st);
        in_pc = 32'h208; in_rd = 5'd3; in_rd_value = 32'h22; in_valid = 1'b1;
        chk("flush_in_ready", in_ready, 1'b0);
        idle(4);
        chk("instret_jump", instret, IEN ? 64'd11 : 64'd0);

        send(32'h300, 5'd7, 32'h55, 1, 1, 32'h400, 1, 1, 0, 1, TV, st);
        idle(4);
        chk("instret_trap", instret, IEN ? 64'd11 : 64'd0);

        send(32'h500, 5'd3, 32'h77, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, st);
        in_valid = 1'b0;
        #2 rst_core_n = 1'b0;
        exp_instret = '0;
        #1 chk_all_zero("async_reset");
        @(negedge clk_core);
        @(negedge clk_core);
        rst_core_n = 1'b1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        idle(4);
        chk("post_reset_instret", instret, 64'd0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
